// File: rtl/hazard_control_unit_if.sv
// Signal bundle between the ID-stage hazard controller and the pipeline.
// master: pipeline side; slave: hazard_control_unit.
interface hazard_control_unit_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       i_rs1_IFID_addr;
  logic [4:0]       i_rs2_IFID_addr;
  logic             i_rs1_used_IFID;
  logic             i_rs2_used_IFID;
  logic             i_clu_MemWrite_IFID;
  logic [4:0]       i_rd_waddr_IDEX;
  logic             i_clu_MemRead_IDEX;
  logic             i_branch_taken_EX;
  logic             i_dmem_busy;
  logic             o_pc_write;
  logic             o_IFID_write;
  logic             o_IFID_flush;
  logic             o_IDEX_bubble;
  logic             o_pipe_freeze;
  logic             o_hazard_err;
  logic [CNT_W-1:0] o_stall_cnt;
  logic [CNT_W-1:0] o_flush_cnt;

  modport master (
    output i_rs1_IFID_addr, i_rs2_IFID_addr,
    output i_rs1_used_IFID, i_rs2_used_IFID,
    output i_clu_MemWrite_IFID,
    output i_rd_waddr_IDEX, i_clu_MemRead_IDEX,
    output i_branch_taken_EX, i_dmem_busy,
    input  o_pc_write, o_IFID_write,
    input  o_IFID_flush, o_IDEX_bubble,
    input  o_pipe_freeze, o_hazard_err,
    input  o_stall_cnt, o_flush_cnt
  );

  modport slave (
    input  i_rs1_IFID_addr, i_rs2_IFID_addr,
    input  i_rs1_used_IFID, i_rs2_used_IFID,
    input  i_clu_MemWrite_IFID,
    input  i_rd_waddr_IDEX, i_clu_MemRead_IDEX,
    input  i_branch_taken_EX, i_dmem_busy,
    output o_pc_write, o_IFID_write,
    output o_IFID_flush, o_IDEX_bubble,
    output o_pipe_freeze, o_hazard_err,
    output o_stall_cnt, o_flush_cnt
  );
endinterface

// File: rtl/hazard_control_unit.sv
// ID-stage hazard controller: load-use stall, branch flush, dmem freeze.
// Optional perf counters enabled by defining HCU_PERF_CNT_EN.
module hazard_control_unit #(
  parameter int FREEZE_MAX = 64,
  parameter int CNT_W      = 16
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  hazard_control_unit_if.slave bus
);
  localparam int FCW = $clog2(FREEZE_MAX + 1);
  localparam logic [FCW-1:0] FMAX = FCW'(FREEZE_MAX);
  localparam logic [FCW-1:0] FONE = FCW'(1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FREEZE = 2'd1,
    ERR    = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           err_q, err_d;

  logic rs1_hit, rs2_hit, lu;
  logic frz, flush_c, stall_c;

  // Store data (rs2) is covered by MEM-to-MEM forwarding, so no stall.
  assign rs1_hit = bus.i_rs1_used_IFID &&
                   (bus.i_rs1_IFID_addr == bus.i_rd_waddr_IDEX);
  assign rs2_hit = bus.i_rs2_used_IFID &&
                   !bus.i_clu_MemWrite_IFID &&
                   (bus.i_rs2_IFID_addr == bus.i_rd_waddr_IDEX);
  assign lu = bus.i_clu_MemRead_IDEX &&
              (bus.i_rd_waddr_IDEX != 5'd0) &&
              (rs1_hit || rs2_hit);

  assign frz     = (state_q == ERR) || bus.i_dmem_busy;
  assign flush_c = !frz && bus.i_branch_taken_EX;
  assign stall_c = !frz && !bus.i_branch_taken_EX && lu;

  always_comb begin
    bus.o_pc_write    = 1'b1;
    bus.o_IFID_write  = 1'b1;
    bus.o_IFID_flush  = 1'b0;
    bus.o_IDEX_bubble = 1'b0;
    bus.o_pipe_freeze = 1'b0;
    unique case (1'b1)
      frz: begin
        bus.o_pc_write    = 1'b0;
        bus.o_IFID_write  = 1'b0;
        bus.o_pipe_freeze = 1'b1;
      end
      flush_c: begin
        bus.o_IFID_flush  = 1'b1;
        bus.o_IDEX_bubble = 1'b1;
      end
      stall_c: begin
        bus.o_pc_write    = 1'b0;
        bus.o_IFID_write  = 1'b0;
        bus.o_IDEX_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.o_hazard_err = err_q;

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    err_d   = err_q;
    unique case (state_q)
      RUN: begin
        if (bus.i_dmem_busy) begin
          state_d = FREEZE;
          fcnt_d  = FONE;
        end
      end
      FREEZE: begin
        if (!bus.i_dmem_busy) begin
          state_d = RUN;
          fcnt_d  = '0;
        end else if (fcnt_q + FONE >= FMAX) begin
          state_d = ERR;
          fcnt_d  = FMAX;
          err_d   = 1'b1;
        end else begin
          fcnt_d = fcnt_q + FONE;
        end
      end
      default: begin
        state_d = ERR;
        err_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= RUN;
      fcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      err_q   <= err_d;
    end
  end

`ifdef HCU_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_c && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_c && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.o_stall_cnt = stall_cnt_q;
  assign bus.o_flush_cnt = flush_cnt_q;
`else
  assign bus.o_stall_cnt = '0;
  assign bus.o_flush_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: directed cases plus
// random traffic against a rule-level reference model.
module tb_hazard_control_unit;
  localparam int FM = 4;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic [5:0]    ctl;
    logic [CW-1:0] stall;
    logic [CW-1:0] flush;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_control_unit_if #(.CNT_W(CW)) bus ();

  hazard_control_unit #(
    .FREEZE_MAX(FM),
    .CNT_W     (CW)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  int  m_streak = 0;
  bit  m_err = 0;
  int  m_stall = 0;
  int  m_flush = 0;

  task automatic cyc(
    input logic       rst, input logic [4:0] rs1,
    input logic [4:0] rs2, input logic u1,
    input logic       u2, input logic mw,
    input logic [4:0] rd, input logic mr,
    input logic       br, input logic busy,
    input bit         chk
  );
    exp_t e;
    bit fz, lu, fl, st;
    @(posedge clk);
    #1;
    rst_n                   = rst;
    bus.i_rs1_IFID_addr     = rs1;
    bus.i_rs2_IFID_addr     = rs2;
    bus.i_rs1_used_IFID     = u1;
    bus.i_rs2_used_IFID     = u2;
    bus.i_clu_MemWrite_IFID = mw;
    bus.i_rd_waddr_IDEX     = rd;
    bus.i_clu_MemRead_IDEX  = mr;
    bus.i_branch_taken_EX   = br;
    bus.i_dmem_busy         = busy;
    lu = mr && rd != 0 &&
         ((u1 && rs1 == rd) || (u2 && rs2 == rd && !mw));
    fz = m_err || busy;
    fl = !fz && br;
    st = !fz && !br && lu;
    // ctl = {pc_write, IFID_write, flush, bubble, freeze, err}
    e.ctl = {!(fz || st), !(fz || st), fl, fl || st, fz, m_err};
`ifdef HCU_PERF_CNT_EN
    e.stall = CW'(m_stall);
    e.flush = CW'(m_flush);
`else
    e.stall = '0;
    e.flush = '0;
`endif
    if (chk) q.push_back(e);
    if (!rst) begin
      m_streak = 0;
      m_err = 0;
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (!m_err) begin
        m_streak = busy ? m_streak + 1 : 0;
        if (m_streak >= FM) m_err = 1;
      end
      if (st && m_stall < CMAX) m_stall++;
      if (fl && m_flush < CMAX) m_flush++;
    end
  endtask

  task automatic idle();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({bus.o_pc_write, bus.o_IFID_write,
             bus.o_IFID_flush, bus.o_IDEX_bubble,
             bus.o_pipe_freeze, bus.o_hazard_err} !== e.ctl) begin
          failures++;
          $display("FAIL ctl t=%0t got=%b exp=%b", $time,
            {bus.o_pc_write, bus.o_IFID_write,
             bus.o_IFID_flush, bus.o_IDEX_bubble,
             bus.o_pipe_freeze, bus.o_hazard_err}, e.ctl);
        end
        checks++;
        if (bus.o_stall_cnt !== e.stall) begin
          failures++;
          $display("FAIL stall_cnt t=%0t got=%0d exp=%0d",
                   $time, bus.o_stall_cnt, e.stall);
        end
        checks++;
        if (bus.o_flush_cnt !== e.flush) begin
          failures++;
          $display("FAIL flush_cnt t=%0t got=%0d exp=%0d",
                   $time, bus.o_flush_cnt, e.flush);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int burst;
    int errage;
    logic [4:0] a, b, d;
    rst_n = 1'b0;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    // lw x5 in EX, add reads x5
    cyc(1, 5, 7, 1, 1, 0, 5, 1, 0, 0, 1);
    cyc(1, 5, 7, 1, 1, 0, 9, 0, 0, 0, 1);
    // sw rs2=5 rs1=2: no stall; sw rs1=5: stall
    cyc(1, 2, 5, 1, 1, 1, 5, 1, 0, 0, 1);
    cyc(1, 5, 3, 1, 1, 1, 5, 1, 0, 0, 1);
    // load-use coincident with taken branch
    cyc(1, 5, 0, 1, 0, 0, 5, 1, 1, 0, 1);
    // rs2 used / unused on a non-store
    cyc(1, 1, 6, 1, 1, 0, 6, 1, 0, 0, 1);
    cyc(1, 1, 6, 1, 0, 0, 6, 1, 0, 0, 1);
    // rd = 0 never stalls
    cyc(1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 1);
    // 3 busy cycles, then flush on release
    repeat (3) cyc(1, 5, 0, 1, 0, 0, 5, 1, 0, 1, 1);
    cyc(1, 5, 0, 1, 0, 0, 5, 1, 1, 0, 1);
    idle();
    // busy held 10 cycles -> timeout error, sticky
    repeat (10) cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    repeat (2) idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    // reset mid-freeze
    repeat (2) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle();
    // stall saturation run
    repeat (CMAX + 3) cyc(1, 3, 0, 1, 0, 0, 3, 1, 0, 0, 1);
    repeat (CMAX + 3) cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    idle();

    burst = 0;
    errage = 0;
    for (int i = 0; i < 3000; i++) begin
      if (burst == 0 && $urandom_range(0, 15) == 0)
        burst = $urandom_range(1, 7);
      a = 5'($urandom_range(0, 3));
      b = 5'($urandom_range(0, 3));
      d = 5'($urandom_range(0, 3));
      errage = m_err ? errage + 1 : 0;
      cyc((errage > 3 || $urandom_range(0, 99) == 0) ? 1'b0 : 1'b1,
          a, b, 1'($urandom), 1'($urandom), 1'($urandom),
          d, 1'($urandom), 1'($urandom_range(0, 4) == 0),
          burst > 0, 1);
      if (burst > 0) burst--;
    end

    for (int k = 0; k < 10 && q.size() > 0; k++)
      @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
